// File: rtl/logicap_seq.sv
// Logic-analyzer capture core: divided sample strobe, sequential multi-stage
// trigger, pre-trigger circular buffer and AXI-Stream readout of one record.
module logicap_seq #(
    parameter int unsigned size    = 32,
    parameter int unsigned depth   = 512,
    parameter int unsigned stages  = 4,
    parameter int unsigned max_div = 32,
    localparam int unsigned DIV_W  = $clog2(max_div),
    localparam int unsigned AW     = $clog2(depth),
    localparam int unsigned SW     = $clog2(stages + 1),
    localparam int unsigned CW     = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [size-1:0]          dinput,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [DIV_W-1:0]         ckdiv,
    input  logic [AW-1:0]            pre_count,
    input  logic [SW-1:0]            num_stages,
    input  logic [stages*size-1:0]   trig_mask,
    input  logic [stages*size-1:0]   trig_type,
    input  logic [stages*size-1:0]   trig_level,
    output logic [size-1:0]          tdata,
    output logic                     tvalid,
    output logic                     tlast,
    input  logic                     tready,
    output logic                     armed,
    output logic                     triggered,
    output logic                     done,
    output logic [SW-1:0]            stage
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        READ = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DIV_W-1:0]        ckdiv_q;
    logic [AW-1:0]           pre_q;
    logic [SW-1:0]           nstg_q;
    logic [stages*size-1:0]  mask_q;
    logic [stages*size-1:0]  type_q;
    logic [stages*size-1:0]  level_q;
    logic [DIV_W-1:0]        div_q;
    logic [AW-1:0]           wr_ptr_q;
    logic [CW-1:0]           cnt_q;
    logic [size-1:0]         prev_q;
    logic                    prev_vld_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [CW-1:0]           rd_cnt_q;
    logic [size-1:0]         tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    armed_q;
    logic                    triggered_q;
    logic                    done_q;
    logic [SW-1:0]           stage_q;
    logic [size-1:0]         mem_q [depth];

    logic                    capture_c;
    logic                    strobe_c;
    logic [size-1:0]         sel_mask_c;
    logic [size-1:0]         sel_type_c;
    logic [size-1:0]         sel_level_c;
    logic [size-1:0]         bit_ok_c;
    logic                    stage_hit_c;
    logic                    trig_c;
    logic [CW-1:0]           post_need_c;
    logic [AW-1:0]           start_c;
    logic                    load_c;

    // Select the trigger word set of the stage currently being evaluated.
    always_comb begin
        sel_mask_c  = '0;
        sel_type_c  = '0;
        sel_level_c = '0;
        for (int k = 0; k < int'(stages); k++) begin
            if (stage_q == SW'(k)) begin
                sel_mask_c  = mask_q[k*size +: size];
                sel_type_c  = type_q[k*size +: size];
                sel_level_c = level_q[k*size +: size];
            end
        end
    end

    // Strobe, per-bit trigger match and readout helpers.
    always_comb begin
        capture_c   = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
        strobe_c    = capture_c && (div_q == '0);
        bit_ok_c    = ~sel_mask_c
                    | (~(dinput ^ sel_level_c)
                       & (~sel_type_c | ({size{prev_vld_q}} & (prev_q ^ sel_level_c))));
        stage_hit_c = &bit_ok_c;
        trig_c      = strobe_c && (state_q == WAIT)
                    && ((nstg_q == '0) || (stage_hit_c && (stage_q == nstg_q - SW'(1))));
        post_need_c = CW'(depth) - CW'(pre_q);
        start_c     = wr_ptr_q - pre_q;
        load_c      = !tvalid_q || tready;
    end

    // Sample buffer write port; only strobes in capture states reach it.
    always_ff @(posedge clk) begin
        if (strobe_c) begin
            mem_q[wr_ptr_q] <= dinput;
        end
    end

    // Capture / readout state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ckdiv_q     <= '0;
            pre_q       <= '0;
            nstg_q      <= '0;
            mask_q      <= '0;
            type_q      <= '0;
            level_q     <= '0;
            div_q       <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (strobe_c) begin
                div_q      <= ckdiv_q;
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                prev_q     <= dinput;
                prev_vld_q <= 1'b1;
            end else if (capture_c) begin
                div_q <= div_q - DIV_W'(1);
            end

            if (abort && (state_q != IDLE)) begin
                state_q  <= IDLE;
                armed_q  <= 1'b0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arm && !abort) begin
                            ckdiv_q     <= ckdiv;
                            pre_q       <= pre_count;
                            nstg_q      <= num_stages;
                            mask_q      <= trig_mask;
                            type_q      <= trig_type;
                            level_q     <= trig_level;
                            triggered_q <= 1'b0;
                            stage_q     <= '0;
                            div_q       <= '0;
                            wr_ptr_q    <= '0;
                            cnt_q       <= '0;
                            prev_vld_q  <= 1'b0;
                            armed_q     <= 1'b1;
                            state_q     <= (pre_count == '0) ? WAIT : PRE;
                        end
                    end
                    PRE: begin
                        if (strobe_c) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == CW'(pre_q) - CW'(1)) begin
                                cnt_q   <= '0;
                                state_q <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (strobe_c) begin
                            if (stage_hit_c && (nstg_q != '0)) begin
                                stage_q <= stage_q + SW'(1);
                            end
                            if (trig_c) begin
                                triggered_q <= 1'b1;
                                rd_ptr_q    <= start_c;
                                rd_cnt_q    <= '0;
                                cnt_q       <= CW'(1);
                                // A record with no post-trigger room ends on the trigger sample.
                                if (post_need_c == CW'(1)) begin
                                    armed_q <= 1'b0;
                                    state_q <= READ;
                                end else begin
                                    state_q <= POST;
                                end
                            end
                        end
                    end
                    POST: begin
                        if (strobe_c) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == post_need_c - CW'(1)) begin
                                armed_q <= 1'b0;
                                state_q <= READ;
                            end
                        end
                    end
                    READ: begin
                        if (tvalid_q && tready && tlast_q) begin
                            done_q   <= 1'b1;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else if (load_c) begin
                            if (rd_cnt_q != CW'(depth)) begin
                                tdata_q  <= mem_q[rd_ptr_q];
                                tvalid_q <= 1'b1;
                                tlast_q  <= (rd_cnt_q == CW'(depth - 1));
                                rd_ptr_q <= rd_ptr_q + AW'(1);
                                rd_cnt_q <= rd_cnt_q + CW'(1);
                            end else begin
                                tvalid_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tdata     = tdata_q;
    assign tvalid    = tvalid_q;
    assign tlast     = tlast_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign stage     = stage_q;

endmodule
